// File: rtl/block_average_downscale.sv
// block_average_downscale: shrinks a greyscale frame by averaging N x N blocks, N = 2^SHIFT_FACTOR
module block_average_downscale #(
  parameter int SHIFT_FACTOR  = 1,
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [14:0] R_ADDR,
  output logic        R_EN,
  input  logic [7:0]  PIXEL_IN,
  output logic [14:0] W_ADDR,
  output logic [7:0]  W_DATA,
  output logic        W_EN
);
  localparam int N  = 1 << SHIFT_FACTOR;
  localparam int AW = 8 + 2 * SHIFT_FACTOR;
  localparam logic [14:0] L_NM1 = 15'(N - 1);
  localparam logic [14:0] L_WIN = 15'(IMG_WIDTH_IN);
  localparam logic [14:0] L_WOUT = 15'(IMG_WIDTH_IN >> SHIFT_FACTOR);
  localparam logic [14:0] L_WM1 = 15'((IMG_WIDTH_IN >> SHIFT_FACTOR) - 1);
  localparam logic [14:0] L_HM1 = 15'((IMG_HEIGHT_IN >> SHIFT_FACTOR) - 1);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FINISH} state_t;
  state_t r_state;
  logic [14:0] r_ox, r_oy, r_dx, r_dy;
  logic [AW-1:0] r_acc;
  logic [14:0] w_ndx, w_ndy, w_nox, w_noy, w_rx, w_ry, w_rdx, w_rdy, w_raddr, w_waddr;
  logic w_last_rd, w_wrap_x, w_last_px;
  logic [AW-1:0] w_sum;
  // next read address: next sample of this block in READ, first sample of the next block in WRITE
  always_comb begin
    w_last_rd = r_dx == L_NM1 && r_dy == L_NM1;
    w_ndx = r_dx == L_NM1 ? '0 : r_dx + 15'd1;
    w_ndy = r_dx == L_NM1 ? r_dy + 15'd1 : r_dy;
    w_wrap_x = r_ox == L_WM1;
    w_last_px = w_wrap_x && r_oy == L_HM1;
    w_nox = w_wrap_x ? '0 : r_ox + 15'd1;
    w_noy = w_wrap_x ? r_oy + 15'd1 : r_oy;
    w_rx = r_state == WRITE ? w_nox : r_ox;
    w_ry = r_state == WRITE ? w_noy : r_oy;
    w_rdx = r_state == WRITE ? '0 : w_ndx;
    w_rdy = r_state == WRITE ? '0 : w_ndy;
    w_raddr = ((w_ry << SHIFT_FACTOR) + w_rdy) * L_WIN + (w_rx << SHIFT_FACTOR) + w_rdx;
    w_waddr = r_oy * L_WOUT + r_ox;
    w_sum = r_acc + AW'(PIXEL_IN);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ox <= '0;
      r_oy <= '0;
      r_dx <= '0;
      r_dy <= '0;
      r_acc <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      R_ADDR <= '0;
      R_EN <= 1'b0;
      W_ADDR <= '0;
      W_DATA <= '0;
      W_EN <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (START) begin
          r_state <= READ;
          r_ox <= '0;
          r_oy <= '0;
          r_dx <= '0;
          r_dy <= '0;
          r_acc <= '0;
          BUSY <= 1'b1;
          R_EN <= 1'b1;
          R_ADDR <= '0;
        end
        READ: begin
          // PIXEL_IN lags R_EN by one cycle, so the first read cycle has nothing to add yet
          r_acc <= (r_dx == '0 && r_dy == '0) ? '0 : w_sum;
          if (w_last_rd) begin
            r_state <= DRAIN;
            R_EN <= 1'b0;
            r_dx <= '0;
            r_dy <= '0;
          end else begin
            r_dx <= w_ndx;
            r_dy <= w_ndy;
            R_ADDR <= w_raddr;
          end
        end
        DRAIN: begin
          r_acc <= w_sum;
          W_DATA <= 8'(w_sum >> (2 * SHIFT_FACTOR));
          W_ADDR <= w_waddr;
          W_EN <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          W_EN <= 1'b0;
          if (w_last_px) begin
            r_state <= FINISH;
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else begin
            r_ox <= w_nox;
            r_oy <= w_noy;
            R_EN <= 1'b1;
            R_ADDR <= w_raddr;
            r_state <= READ;
          end
        end
        FINISH: begin
          DONE <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_average_downscale.sv
// tb_block_average_downscale: randomized frames checked against a block-mean reference model
module tb_block_average_downscale;
  localparam int WIN = 160, HIN = 120, WO = 80, HO = 60, NPIX = 4800, NRD = 19200;
  logic CLK = 0, RESET = 1, START = 0;
  logic BUSY, DONE, R_EN, W_EN;
  logic [14:0] R_ADDR, W_ADDR;
  logic [7:0] W_DATA, PIXEL_IN;
  logic [7:0] mem [NRD];
  int exp_px [NPIX];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, first_rd = -1, done_cyc = -1, done_n = 0, done_busy = 0, overlap = 0;
  int ra_q [$], wa_q [$], wd_q [$];

  always #5 CLK = ~CLK;

  block_average_downscale dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
    .R_ADDR(R_ADDR), .R_EN(R_EN), .PIXEL_IN(PIXEL_IN),
    .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN)
  );

  always @(posedge CLK) if (R_EN) PIXEL_IN <= (int'(R_ADDR) < NRD) ? mem[R_ADDR] : 8'h00;

  always @(negedge CLK) begin
    cyc++;
    if (R_EN) begin
      ra_q.push_back(int'(R_ADDR));
      if (first_rd < 0) first_rd = cyc;
    end
    if (W_EN) begin
      wa_q.push_back(int'(W_ADDR));
      wd_q.push_back(int'(W_DATA));
    end
    if (R_EN && W_EN) overlap++;
    if (DONE) begin
      done_n++;
      done_cyc = cyc;
      done_busy = int'(BUSY);
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    ra_q.delete();
    wa_q.delete();
    wd_q.delete();
    first_rd = -1;
    done_cyc = -1;
    done_n = 0;
    overlap = 0;
  endtask

  task automatic pulse_start();
    tick();
    START = 1;
    tick();
    START = 0;
  endtask

  task automatic build_exp();
    int s;
    for (int oy = 0; oy < HO; oy++)
      for (int ox = 0; ox < WO; ox++) begin
        s = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            s += int'(mem[(oy * 2 + dy) * WIN + ox * 2 + dx]);
        exp_px[oy * WO + ox] = s / 4;
      end
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_n == 0; k++) tick();
    n_cmp++;
    if (done_n == 0) begin
      n_bad++;
      $display("FAIL done_timeout: got no DONE, required one within %0d cycles", budget);
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int k = 0; k < budget && wa_q.size() < n; k++) tick();
    n_cmp++;
    if (wa_q.size() < n) begin
      n_bad++;
      $display("FAIL write_timeout: got %0d writes, required %0d", wa_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({BUSY, DONE, R_EN, W_EN, R_ADDR, W_ADDR, W_DATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required all zero", {BUSY, DONE, R_EN, W_EN, R_ADDR, W_ADDR, W_DATA});
    end
    RESET = 0;
    clear_mon();
    repeat (5) tick();
    n_cmp++;
    if (BUSY !== 1'b0 || ra_q.size() != 0 || done_n != 0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b reads=%0d done=%0d, required 0/0/0", BUSY, ra_q.size(), done_n);
    end
  endtask

  task automatic test_random_frame();
    int er [4] = '{0, 1, 160, 161};
    int el [4] = '{19038, 19039, 19198, 19199};
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 10; mem[1] = 20; mem[160] = 30; mem[161] = 41;
    mem[2] = 0; mem[3] = 0; mem[162] = 0; mem[163] = 3;
    build_exp();
    clear_mon();
    pulse_start();
    wait_done(30000);
    n_cmp++;
    if (ra_q.size() != NRD) begin
      n_bad++;
      $display("FAIL read_count: got %0d, required %0d", ra_q.size(), NRD);
    end
    n_cmp++;
    if (wa_q.size() != NPIX) begin
      n_bad++;
      $display("FAIL write_count: got %0d, required %0d", wa_q.size(), NPIX);
    end
    if (ra_q.size() == NRD)
      for (int i = 0; i < 4; i++) begin
        n_cmp += 2;
        if (ra_q[i] != er[i]) begin
          n_bad++;
          $display("FAIL first_raddr[%0d]: got %0d, required %0d", i, ra_q[i], er[i]);
        end
        if (ra_q[NRD - 4 + i] != el[i]) begin
          n_bad++;
          $display("FAIL last_raddr[%0d]: got %0d, required %0d", i, ra_q[NRD - 4 + i], el[i]);
        end
      end
    if (wa_q.size() == NPIX) begin
      n_cmp += 2;
      if (wd_q[0] != 25) begin
        n_bad++;
        $display("FAIL mixed_block: got %0d, required 25", wd_q[0]);
      end
      if (wd_q[1] != 0) begin
        n_bad++;
        $display("FAIL small_block: got %0d, required 0", wd_q[1]);
      end
      for (int i = 0; i < NPIX; i++) begin
        n_cmp += 2;
        if (wa_q[i] != i) begin
          n_bad++;
          $display("FAIL waddr[%0d]: got %0d, required %0d", i, wa_q[i], i);
        end
        if (wd_q[i] != exp_px[i]) begin
          n_bad++;
          $display("FAIL wdata[%0d]: got %0d, required %0d", i, wd_q[i], exp_px[i]);
        end
      end
    end
    n_cmp++;
    if (done_cyc - first_rd != 28800) begin
      n_bad++;
      $display("FAIL frame_latency: got %0d cycles, required 28800", done_cyc - first_rd);
    end
    n_cmp++;
    if (done_busy != 0 || overlap != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusion: got busy_at_done=%0d overlaps=%0d, required 0/0", done_busy, overlap);
    end
  endtask

  task automatic test_restart_and_busy_start();
    int bad;
    tick();
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL done_width: got DONE=%b one cycle later, required 0", DONE);
    end
    foreach (mem[i]) mem[i] = 8'h80;
    clear_mon();
    tick();
    tick();
    START = 1;
    tick();
    START = 0;
    n_cmp++;
    if (R_EN !== 1'b1 || R_ADDR !== 15'd0 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: got ren=%b raddr=%0d busy=%b, required 1/0/1", R_EN, R_ADDR, BUSY);
    end
    repeat (9) tick();
    START = 1;
    tick();
    START = 0;
    repeat (489) tick();
    START = 1;
    tick();
    START = 0;
    wait_done(30000);
    START = 1;
    tick();
    START = 0;
    repeat (20) tick();
    bad = 0;
    foreach (wd_q[i]) if (wd_q[i] != 8'h80) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL gray_frame: got %0d pixels not 128, required 0", bad);
    end
    n_cmp++;
    if (wa_q.size() != NPIX || done_n != 1) begin
      n_bad++;
      $display("FAIL busy_start: got writes=%0d dones=%0d, required %0d/1", wa_q.size(), done_n, NPIX);
    end
    n_cmp++;
    if (ra_q.size() != NRD || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL start_at_done: got reads=%0d busy=%b, required %0d/0", ra_q.size(), BUSY, NRD);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    foreach (mem[i]) mem[i] = 8'hFF;
    clear_mon();
    pulse_start();
    wait_writes(100, 2000);
    tick();
    tick();
    n_cmp++;
    if (R_EN !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_frame_read: got ren=%b, required 1", R_EN);
    end
    #2 RESET = 1;
    #1;
    n_cmp++;
    if ({BUSY, DONE, R_EN, W_EN, R_ADDR, W_ADDR, W_DATA} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %b, required all zero", {BUSY, DONE, R_EN, W_EN, R_ADDR, W_ADDR, W_DATA});
    end
    bad = 0;
    foreach (wd_q[i]) if (wd_q[i] != 255) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL white_saturation: got %0d pixels not 255, required 0", bad);
    end
    tick();
    tick();
    RESET = 0;
    clear_mon();
    repeat (30) tick();
    n_cmp++;
    if (done_n != 0 || ra_q.size() != 0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL abandoned_frame: got dones=%0d reads=%0d busy=%b, required 0/0/0", done_n, ra_q.size(), BUSY);
    end
    pulse_start();
    wait_writes(200, 2000);
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] != i || wd_q[i] != 255) bad++;
    n_cmp++;
    if (bad != 0 || ra_q.size() == 0 || ra_q[0] != 0) begin
      n_bad++;
      $display("FAIL rerun_after_reset: got %0d bad writes, first raddr %0d, required 0 and 0", bad, ra_q.size() ? ra_q[0] : -1);
    end
    RESET = 1;
    tick();
    RESET = 0;
  endtask

  initial begin
    test_reset();
    test_random_frame();
    test_restart_and_busy_start();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/block_average_downscale.md
Name: block_average_downscale

Overview:
- Zoom-out counterpart of the nearest-neighbor zoom-in path. Reads a source greyscale frame from the on-chip image memory and writes a reduced frame to an output memory.
- Each output pixel is the truncated mean of an N×N source block, with N = 2^SHIFT_FACTOR.
- Sequential raster engine with synchronous-read memory timing. Started by the control FSM; signals completion with a one-cycle DONE pulse.

Parameters:
- SHIFT_FACTOR, 1, log2 of block size N (legal values: 1 or 2).
- IMG_WIDTH_IN, 160, source width in pixels (multiple of N).
- IMG_HEIGHT_IN, 120, source height in pixels (multiple of N).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request to process a frame; sampled only in IDLE.
- BUSY  output  1  high from the first READ cycle through the final WRITE cycle.
- DONE  output  1  one-cycle pulse the cycle after the final write.
- R_ADDR  output  15  source memory read address.
- R_EN  output  1  read strobe; memory returns data one cycle later.
- PIXEL_IN  input  8  source read data; valid the cycle after R_EN.
- W_ADDR  output  15  output memory write address.
- W_DATA  output  8  output pixel value.
- W_EN  output  1  write strobe; one cycle per output pixel.

Behaviour:
- Reset: the following are cleared to 0 and the FSM goes to IDLE:
  - all outputs;
  - the ox/oy output counters;
  - the dx/dy block counters;
  - the accumulator.
- Reset is asynchronous and valid at any cycle. A frame in progress is abandoned; no DONE is generated.
- Derived sizes:
  - W_OUT = IMG_WIDTH_IN >> SHIFT_FACTOR.
  - H_OUT = IMG_HEIGHT_IN >> SHIFT_FACTOR.
  - Accumulator width = 8 + 2·SHIFT_FACTOR bits, so it cannot overflow (4×255 = 1020; 16×255 = 4080).
- IDLE:
  - BUSY = 0, R_EN = 0, W_EN = 0.
  - START = 1 → clear ox, oy, dx, dy and the accumulator; go to READ.
- READ (N² cycles per output pixel):
  - R_EN = 1 every cycle.
  - R_ADDR = (oy·N + dy)·IMG_WIDTH_IN + (ox·N + dx).
  - Read order within a block is row-major: dx increments; on wrap dx → 0 and dy increments.
  - From the second READ cycle on, acc += PIXEL_IN. The first READ cycle loads acc with 0.
  - After the last read (dx = dy = N−1) → DRAIN.
- DRAIN (1 cycle):
  - R_EN = 0; acc += PIXEL_IN (last sample) → WRITE.
- WRITE (1 cycle):
  - W_EN = 1.
  - W_ADDR = oy·W_OUT + ox.
  - W_DATA = acc >> (2·SHIFT_FACTOR), truncating with no rounding.
  - Advance ox; on ox = W_OUT−1, ox → 0 and oy increments.
  - If this was the final pixel (ox = W_OUT−1 and oy = H_OUT−1) → FINISH; else → READ.
- FINISH (1 cycle):
  - DONE = 1, BUSY = 0 → IDLE.
- Held values: R_ADDR, W_ADDR and W_DATA hold their last value when their strobe is low.
- Strobes:
  - R_EN and W_EN are never high in the same cycle.
  - DONE is never high in the same cycle as BUSY.
- Cycle count: N² + 2 cycles per output pixel. For defaults, 6 × 4800 = 28800 cycles from the first READ cycle to DONE.
- START handling:
  - START while BUSY or in FINISH is ignored; no queuing.
  - START asserted in the same cycle DONE is high is ignored.
- PIXEL_IN is don't-care whenever R_EN was low in the previous cycle.

Test Plan:
- Address sequence, first block (defaults): START pulse → R_ADDR 0, 1, 160, 161 on consecutive R_EN cycles; then W_EN with W_ADDR = 0. Last block: R_ADDR 19038, 19039, 19198, 19199; then W_ADDR = 4799.
- Arithmetic, mixed block: block {10, 20, 30, 41} → W_DATA = 25 (sum 101 >> 2, truncation). Block {0, 0, 0, 3} → W_DATA = 0.
- Arithmetic, saturated frame: all-0xFF source → every W_DATA = 0xFF, with no wrap. All-0x80 source → every W_DATA = 0x80; exactly 4800 W_EN pulses.
- Timing: DONE high exactly 28800 cycles after the first READ cycle, for 1 cycle. BUSY falls in the same cycle. START 3 cycles later restarts at R_ADDR 0.
- START while busy: START pulses at cycles 10 and 500 → no effect; write count remains 4800 and a single DONE is produced.
- RESET mid-frame (at pixel 100, during READ) → all outputs 0 immediately. After release, IDLE with no DONE; a new START re-processes from W_ADDR 0.
